keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_pkg.sv | 42 ++++
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/bin_to_one_hot.sv | 14 +
 rtl/keypad_scanner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared FSM states, key codes and keymap for the keypad scanner
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_HELD,
    ST_RELEASE
  } kp_state_e;

  typedef logic [3:0] key_code_t;

  localparam key_code_t CODE_0 = 4'h0;
  localparam key_code_t CODE_1 = 4'h1;
  localparam key_code_t CODE_2 = 4'h2;
  localparam key_code_t CODE_3 = 4'h3;
  localparam key_code_t CODE_4 = 4'h4;
  localparam key_code_t CODE_5 = 4'h5;
  localparam key_code_t CODE_6 = 4'h6;
  localparam key_code_t CODE_7 = 4'h7;
  localparam key_code_t CODE_8 = 4'h8;
  localparam key_code_t CODE_9 = 4'h9;
  localparam key_code_t CODE_A = 4'hA;
  localparam key_code_t CODE_B = 4'hB;
  localparam key_code_t CODE_C = 4'hC;
  localparam key_code_t CODE_D = 4'hD;
  localparam key_code_t CODE_E = 4'hE;
  localparam key_code_t CODE_F = 4'hF;

  // Indexed by {row, col}; element 0 is row0/col0.
  localparam logic [15:0][3:0] KEYMAP = {
    CODE_D, CODE_E, CODE_F, CODE_0,
    CODE_C, CODE_9, CODE_8, CODE_7,
    CODE_B, CODE_6, CODE_5, CODE_4,
    CODE_A, CODE_3, CODE_2, CODE_1
  };

  function automatic key_code_t key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - confirmed-key handshake between scanner and consumer
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  key_code_t key_code;
  logic      key_valid;
  logic      key_ack;
  logic      key_held;
  logic      overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ack
  );

endinterface

// File: rtl/bin_to_one_hot.sv
// rtl/bin_to_one_hot.sv - binary index to one-hot decoder
module bin_to_one_hot #(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]        bin,
  output logic [(1<<IN_W)-1:0]   one_hot
);

  always_comb begin
    one_hot      = '0;
    one_hot[bin] = 1'b1;
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with scan-level debounce and key handshake
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       col_in,
  output logic [3:0]       row_out,
  keypad_scanner_if.master key_if
);

  localparam int            TW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [3:0]    DEB       = 4'(DEBOUNCE_SCANS);

  logic [3:0]    col_s1_q, col_s2_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    hits_q, hits_d;
  key_code_t     scan_code_q, scan_code_d;
  kp_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  key_code_t     cand_q, cand_d;
  key_code_t     key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          overrun_q, overrun_d;

  logic          row_last, scan_done, single_hit, cand_match, press_evt, ack_hit;
  logic [2:0]    row_zeros, hit_sum;
  logic [1:0]    row_col, row_hits, base_hits, tot_hits;
  key_code_t     tot_code;
  logic [3:0]    cnt_inc;
  logic [3:0]    row_one_hot;

  bin_to_one_hot #(.IN_W(2)) u_row_dec (
    .bin     (row_q),
    .one_hot (row_one_hot)
  );

  assign row_out = ~row_one_hot;

  // Hit counts saturate at 2 so that any second low bit marks the scan as MULTI.
  always_comb begin
    row_zeros = '0;
    row_col   = '0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_s2_q[c]) begin
        row_zeros = row_zeros + 3'd1;
        row_col   = 2'(c);
      end
    end
    row_hits   = (row_zeros > 3'd1) ? 2'd2 : row_zeros[1:0];
    base_hits  = (row_q == 2'd0) ? 2'd0 : hits_q;
    hit_sum    = {1'b0, base_hits} + {1'b0, row_hits};
    tot_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    tot_code   = (row_hits == 2'd1) ? key_lookup(row_q, row_col)
                                    : ((row_q == 2'd0) ? CODE_0 : scan_code_q);
    row_last   = (tick_q == TICK_LAST);
    scan_done  = row_last && (row_q == 2'd3);
    single_hit = (tot_hits == 2'd1);
    cand_match = single_hit && (tot_code == cand_q);

    tick_d      = row_last ? '0 : tick_q + 1'b1;
    row_d       = row_last ? row_q + 2'd1 : row_q;
    hits_d      = row_last ? tot_hits : hits_q;
    scan_code_d = row_last ? tot_code : scan_code_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    press_evt = 1'b0;
    cnt_inc   = cnt_q + 4'd1;
    if (scan_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (single_hit) begin
            cand_d = tot_code;
            cnt_d  = 4'd1;
            if (DEB <= 4'd1) begin
              press_evt = 1'b1;
              state_d   = ST_HELD;
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (cand_match) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB) begin
              press_evt = 1'b1;
              state_d   = ST_HELD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!cand_match) begin
            cnt_d   = 4'd1;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (cand_match) begin
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A press landing in the same cycle as an ack replaces the key without flagging overrun.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    ack_hit     = key_if.key_ack && key_valid_q;
    if (ack_hit) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (press_evt) begin
      key_code_d  = cand_d;
      key_valid_d = 1'b1;
      if (key_valid_q && !key_if.key_ack) overrun_d = 1'b1;
    end
    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      tick_q      <= '0;
      row_q       <= 2'd0;
      hits_q      <= 2'd0;
      scan_code_q <= CODE_0;
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= CODE_0;
      key_code_q  <= CODE_0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      col_s1_q    <= col_in;
      col_s2_q    <= col_s1_q;
      tick_q      <= tick_d;
      row_q       <= row_d;
      hits_q      <= hits_d;
      scan_code_q <= scan_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_held  = key_held_q;
  assign key_if.overrun   = overrun_q;

endmodule
